// File: rtl/snoop_pkg.sv
// Shared encodings for the MSI snoop responder and the CPU-side cache controller.
package snoop_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned MSG_W = 2;

  localparam logic [ST_W-1:0] ST_INV = 2'b00;
  localparam logic [ST_W-1:0] ST_EXC = 2'b01;
  localparam logic [ST_W-1:0] ST_SHR = 2'b10;

  localparam logic [MSG_W-1:0] MSG_RD_MISS = 2'b00;
  localparam logic [MSG_W-1:0] MSG_WR_MISS = 2'b01;
  localparam logic [MSG_W-1:0] MSG_INV     = 2'b10;
  localparam logic [MSG_W-1:0] MSG_EMPTY   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_WRITEBACK = 2'd2,
    S_DONE      = 2'd3
  } snoop_fsm_e;

  // Line state after a snoop hit by the given bus message.
  function automatic logic [ST_W-1:0] snoop_next_state(input logic [ST_W-1:0] st,
                                                       input logic [MSG_W-1:0] msg);
    logic [ST_W-1:0] nxt;
    nxt = st;
    case (msg)
      MSG_RD_MISS: if (st == ST_EXC) nxt = ST_SHR;
      MSG_WR_MISS,
      MSG_INV:     nxt = ST_INV;
      default:     nxt = st;
    endcase
    return nxt;
  endfunction

  // The unused 2'b11 encoding is stored as invalid.
  function automatic logic [ST_W-1:0] snoop_norm_state(input logic [ST_W-1:0] st);
    return (st == 2'b11) ? ST_INV : st;
  endfunction

endpackage

// File: rtl/snoop_bus_responder_if.sv
// Bus, CPU-update, CPU-read and write-back signals of the snoop responder.
interface snoop_bus_responder_if #(
  parameter int unsigned LINES = 4,
  parameter int unsigned TAG_W = 8
);
  localparam int unsigned IDX_W = $clog2(LINES);

  logic             bus_valid;
  logic             bus_ready;
  logic [1:0]       bus_msg;
  logic [IDX_W-1:0] bus_idx;
  logic [TAG_W-1:0] bus_tag;

  logic             cpu_upd_valid;
  logic             cpu_upd_ready;
  logic [IDX_W-1:0] cpu_upd_idx;
  logic [TAG_W-1:0] cpu_upd_tag;
  logic [1:0]       cpu_upd_state;

  logic [IDX_W-1:0] cpu_rd_idx;
  logic [1:0]       cpu_rd_state;
  logic [TAG_W-1:0] cpu_rd_tag;

  logic             wb_valid;
  logic             wb_ready;
  logic [IDX_W-1:0] wb_idx;
  logic [TAG_W-1:0] wb_tag;

  logic             abort_mem;
  logic             snoop_done;
  logic             snoop_hit;

  modport master (
    output bus_valid, bus_msg, bus_idx, bus_tag,
    output cpu_upd_valid, cpu_upd_idx, cpu_upd_tag, cpu_upd_state, cpu_rd_idx, wb_ready,
    input  bus_ready, cpu_upd_ready, cpu_rd_state, cpu_rd_tag,
    input  wb_valid, wb_idx, wb_tag, abort_mem, snoop_done, snoop_hit
  );

  modport slave (
    input  bus_valid, bus_msg, bus_idx, bus_tag,
    input  cpu_upd_valid, cpu_upd_idx, cpu_upd_tag, cpu_upd_state, cpu_rd_idx, wb_ready,
    output bus_ready, cpu_upd_ready, cpu_rd_state, cpu_rd_tag,
    output wb_valid, wb_idx, wb_tag, abort_mem, snoop_done, snoop_hit
  );

endinterface

// File: rtl/snoop_line_array.sv
// Per-line tag/state storage: combinational CPU read, registered lookup, CPU and snoop writes.
module snoop_line_array
  import snoop_pkg::*;
#(
  parameter  int unsigned LINES = 4,
  parameter  int unsigned TAG_W = 8,
  localparam int unsigned IDX_W = $clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [ST_W-1:0]  rd_state_o,
  output logic [TAG_W-1:0] rd_tag_o,
  input  logic             lk_en_i,
  input  logic [IDX_W-1:0] lk_idx_i,
  output logic [ST_W-1:0]  lk_state_o,
  output logic [TAG_W-1:0] lk_tag_o,
  input  logic             cpu_we_i,
  input  logic [IDX_W-1:0] cpu_idx_i,
  input  logic [TAG_W-1:0] cpu_tag_i,
  input  logic [ST_W-1:0]  cpu_state_i,
  input  logic             sn_we_i,
  input  logic [IDX_W-1:0] sn_idx_i,
  input  logic [ST_W-1:0]  sn_state_i
);

  logic [ST_W-1:0]  st_q  [LINES];
  logic [TAG_W-1:0] tag_q [LINES];
  logic [ST_W-1:0]  lk_state_q;
  logic [TAG_W-1:0] lk_tag_q;

  logic cpu_wins_c, cpu_fwd_c, sn_fwd_c;

  assign cpu_wins_c = cpu_we_i && !(sn_we_i && (sn_idx_i == cpu_idx_i));
  assign cpu_fwd_c  = cpu_wins_c && (cpu_idx_i == lk_idx_i);
  assign sn_fwd_c   = sn_we_i && (sn_idx_i == lk_idx_i);

  assign rd_state_o = st_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign lk_state_o = lk_state_q;
  assign lk_tag_o   = lk_tag_q;

  // A write landing on the same edge as the lookup is forwarded so the lookup sees it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LINES); i++) begin
        st_q[i]  <= ST_INV;
        tag_q[i] <= '0;
      end
      lk_state_q <= ST_INV;
      lk_tag_q   <= '0;
    end else begin
      if (sn_we_i) st_q[sn_idx_i] <= sn_state_i;
      if (cpu_wins_c) begin
        st_q[cpu_idx_i]  <= cpu_state_i;
        tag_q[cpu_idx_i] <= cpu_tag_i;
      end
      if (lk_en_i) begin
        lk_state_q <= sn_fwd_c ? sn_state_i : (cpu_fwd_c ? cpu_state_i : st_q[lk_idx_i]);
        lk_tag_q   <= cpu_fwd_c ? cpu_tag_i : tag_q[lk_idx_i];
      end
    end
  end

endmodule

// File: rtl/snoop_bus_responder.sv
// Snoop side of the MSI controller: looks up bus messages, downgrades lines, requests write-backs.
// Optional SNOOP_TRACE_EN prints each completed snoop transaction.
module snoop_bus_responder
  import snoop_pkg::*;
#(
  parameter int unsigned LINES = 4,
  parameter int unsigned TAG_W = 8
) (
  input logic                 clock,
  input logic                 reset_n,
  snoop_bus_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LINES);

  snoop_fsm_e       state_q, state_d;
  logic [MSG_W-1:0] cap_msg_q, cap_msg_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [TAG_W-1:0] cap_tag_q, cap_tag_d;
  logic             hit_q, hit_d;
  logic [ST_W-1:0]  new_st_q, new_st_d;
  logic             wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;
  logic             snoop_hit_q, snoop_hit_d;
  logic             bus_ready_q, bus_ready_d;
  logic             upd_ready_q, upd_ready_d;

  logic             lk_en, sn_we, cpu_we;
  logic [ST_W-1:0]  lk_state;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit_c, lk_wb_c;

  assign cpu_we = bus.cpu_upd_valid && upd_ready_q;

  snoop_line_array #(.LINES(LINES), .TAG_W(TAG_W)) u_lines (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_idx_i    (bus.cpu_rd_idx),
    .rd_state_o  (bus.cpu_rd_state),
    .rd_tag_o    (bus.cpu_rd_tag),
    .lk_en_i     (lk_en),
    .lk_idx_i    (bus.bus_idx),
    .lk_state_o  (lk_state),
    .lk_tag_o    (lk_tag),
    .cpu_we_i    (cpu_we),
    .cpu_idx_i   (bus.cpu_upd_idx),
    .cpu_tag_i   (bus.cpu_upd_tag),
    .cpu_state_i (snoop_norm_state(bus.cpu_upd_state)),
    .sn_we_i     (sn_we),
    .sn_idx_i    (cap_idx_q),
    .sn_state_i  (new_st_q)
  );

  // Empty messages never hit; only an exclusive line hit by a miss needs a write-back.
  assign lk_hit_c = (cap_msg_q != MSG_EMPTY) && (lk_state != ST_INV) && (lk_tag == cap_tag_q);
  assign lk_wb_c  = lk_hit_c && (lk_state == ST_EXC) &&
                    ((cap_msg_q == MSG_RD_MISS) || (cap_msg_q == MSG_WR_MISS));

  always_comb begin
    state_d     = state_q;
    cap_msg_d   = cap_msg_q;
    cap_idx_d   = cap_idx_q;
    cap_tag_d   = cap_tag_q;
    hit_d       = hit_q;
    new_st_d    = new_st_q;
    wb_valid_d  = 1'b0;
    wb_idx_d    = wb_idx_q;
    wb_tag_d    = wb_tag_q;
    abort_d     = 1'b0;
    done_d      = 1'b0;
    snoop_hit_d = 1'b0;
    lk_en       = 1'b0;
    sn_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.bus_valid) begin
          cap_msg_d = bus.bus_msg;
          cap_idx_d = bus.bus_idx;
          cap_tag_d = bus.bus_tag;
          lk_en     = 1'b1;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d    = lk_hit_c;
        new_st_d = lk_hit_c ? snoop_next_state(lk_state, cap_msg_q) : lk_state;
        if (lk_wb_c) begin
          state_d    = S_WRITEBACK;
          wb_valid_d = 1'b1;
          abort_d    = 1'b1;
          wb_idx_d   = cap_idx_q;
          wb_tag_d   = cap_tag_q;
        end else begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          snoop_hit_d = lk_hit_c;
        end
      end
      S_WRITEBACK: begin
        wb_valid_d = 1'b1;
        if (bus.wb_ready) begin
          wb_valid_d  = 1'b0;
          state_d     = S_DONE;
          done_d      = 1'b1;
          snoop_hit_d = hit_q;
        end
      end
      S_DONE: begin
        sn_we   = hit_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    bus_ready_d = (state_d == S_IDLE);
    upd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cap_msg_q   <= MSG_RD_MISS;
      cap_idx_q   <= '0;
      cap_tag_q   <= '0;
      hit_q       <= 1'b0;
      new_st_q    <= ST_INV;
      wb_valid_q  <= 1'b0;
      wb_idx_q    <= '0;
      wb_tag_q    <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      snoop_hit_q <= 1'b0;
      bus_ready_q <= 1'b1;
      upd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cap_msg_q   <= cap_msg_d;
      cap_idx_q   <= cap_idx_d;
      cap_tag_q   <= cap_tag_d;
      hit_q       <= hit_d;
      new_st_q    <= new_st_d;
      wb_valid_q  <= wb_valid_d;
      wb_idx_q    <= wb_idx_d;
      wb_tag_q    <= wb_tag_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      snoop_hit_q <= snoop_hit_d;
      bus_ready_q <= bus_ready_d;
      upd_ready_q <= upd_ready_d;
    end
  end

  assign bus.bus_ready     = bus_ready_q;
  assign bus.cpu_upd_ready = upd_ready_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_idx        = wb_idx_q;
  assign bus.wb_tag        = wb_tag_q;
  assign bus.abort_mem     = abort_q;
  assign bus.snoop_done    = done_q;
  assign bus.snoop_hit     = snoop_hit_q;

`ifdef SNOOP_TRACE_EN
  always_ff @(posedge clock) begin
    if (state_q == S_DONE) begin
      $display("snoop: msg=%0d idx=%0d tag=%0h state %02b -> %02b",
               cap_msg_q, cap_idx_q, cap_tag_q, lk_state, new_st_q);
      if (hit_q && (lk_state == ST_EXC) &&
          ((cap_msg_q == MSG_RD_MISS) || (cap_msg_q == MSG_WR_MISS)))
        $display("Write-back block; abort memory access");
    end
  end
`else
`endif

endmodule

// File: tb/tb_snoop_bus_responder.sv
// Randomized and directed bench for snoop_bus_responder against an MSI line-table model.
module tb_snoop_bus_responder;

  localparam int unsigned LINES = 4;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned IDX_W = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  snoop_bus_responder_if #(.LINES(LINES), .TAG_W(TAG_W)) sb ();

  snoop_bus_responder #(.LINES(LINES), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sb)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: 0 invalid, 1 exclusive, 2 shared
  logic [1:0]       ref_st  [LINES];
  logic [TAG_W-1:0] ref_tag [LINES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(LINES); i++) begin
      ref_st[i]  = 2'd0;
      ref_tag[i] = '0;
    end
  endtask

  task automatic model_update(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                              input logic [1:0] st);
    ref_st[idx]  = (st == 2'd3) ? 2'd0 : st;
    ref_tag[idx] = tag;
  endtask

  // Snoop rules: hit needs a real message, a valid line and a tag match.
  task automatic model_snoop(input logic [1:0] msg, input logic [IDX_W-1:0] idx,
                             input logic [TAG_W-1:0] tag, output bit hit, output bit wb);
    hit = (msg != 2'd3) && (ref_st[idx] != 2'd0) && (ref_tag[idx] == tag);
    wb  = hit && (ref_st[idx] == 2'd1) && (msg <= 2'd1);
    if (hit) begin
      if (msg == 2'd0) ref_st[idx] = 2'd2;
      else             ref_st[idx] = 2'd0;
    end
  endtask

  task automatic idle_inputs();
    sb.bus_valid     = 1'b0;
    sb.bus_msg       = 2'd0;
    sb.bus_idx       = '0;
    sb.bus_tag       = '0;
    sb.cpu_upd_valid = 1'b0;
    sb.cpu_upd_idx   = '0;
    sb.cpu_upd_tag   = '0;
    sb.cpu_upd_state = 2'd0;
    sb.cpu_rd_idx    = '0;
    sb.wb_ready      = 1'b0;
  endtask

  task automatic check_lines(input string tag);
    for (int i = 0; i < int'(LINES); i++) begin
      sb.cpu_rd_idx = IDX_W'(i);
      #1;
      check($sformatf("%s_st%0d", tag, i), 32'(sb.cpu_rd_state), 32'(ref_st[i]));
      check($sformatf("%s_tag%0d", tag, i), 32'(sb.cpu_rd_tag), 32'(ref_tag[i]));
    end
  endtask

  task automatic cpu_upd(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [1:0] st);
    @(negedge clock);
    check("upd_ready_idle", 32'(sb.cpu_upd_ready), 32'd1);
    sb.cpu_upd_valid = 1'b1;
    sb.cpu_upd_idx   = idx;
    sb.cpu_upd_tag   = tag;
    sb.cpu_upd_state = st;
    @(posedge clock);
    #1 sb.cpu_upd_valid = 1'b0;
    model_update(idx, tag, st);
  endtask

  task automatic bus_txn(input logic [1:0] msg, input logic [IDX_W-1:0] idx,
                         input logic [TAG_W-1:0] tag, input bit upd,
                         input logic [IDX_W-1:0] uidx, input logic [TAG_W-1:0] utag,
                         input logic [1:0] ust, input int wbd, input bit lines);
    bit eh, ew;
    @(negedge clock);
    check("bus_ready_idle", 32'(sb.bus_ready), 32'd1);
    sb.bus_valid     = 1'b1;
    sb.bus_msg       = msg;
    sb.bus_idx       = idx;
    sb.bus_tag       = tag;
    sb.cpu_upd_valid = upd;
    sb.cpu_upd_idx   = uidx;
    sb.cpu_upd_tag   = utag;
    sb.cpu_upd_state = ust;
    @(posedge clock);
    #1;
    sb.bus_valid     = 1'b0;
    sb.cpu_upd_valid = 1'b0;
    if (upd) model_update(uidx, utag, ust);
    model_snoop(msg, idx, tag, eh, ew);
    @(negedge clock);
    check("upd_ready_lookup", 32'(sb.cpu_upd_ready), 32'd0);
    check("bus_ready_lookup", 32'(sb.bus_ready), 32'd0);
    check("done_lookup", 32'(sb.snoop_done), 32'd0);
    @(negedge clock);
    if (ew) begin
      check("abort_pulse", 32'(sb.abort_mem), 32'd1);
      check("wb_valid", 32'(sb.wb_valid), 32'd1);
      check("wb_idx", 32'(sb.wb_idx), 32'(idx));
      check("wb_tag", 32'(sb.wb_tag), 32'(tag));
      check("done_wb", 32'(sb.snoop_done), 32'd0);
      repeat (wbd) begin
        @(negedge clock);
        check("wb_hold", 32'(sb.wb_valid), 32'd1);
        check("abort_once", 32'(sb.abort_mem), 32'd0);
        check("done_wait", 32'(sb.snoop_done), 32'd0);
      end
      sb.wb_ready = 1'b1;
      @(posedge clock);
      #1 sb.wb_ready = 1'b0;
      @(negedge clock);
    end
    check("snoop_done", 32'(sb.snoop_done), 32'd1);
    check("snoop_hit", 32'(sb.snoop_hit), 32'(eh));
    check("wb_idle", 32'(sb.wb_valid), 32'd0);
    check("abort_idle", 32'(sb.abort_mem), 32'd0);
    check("upd_ready_done", 32'(sb.cpu_upd_ready), 32'd0);
    @(negedge clock);
    check("done_pulse", 32'(sb.snoop_done), 32'd0);
    check("bus_ready_back", 32'(sb.bus_ready), 32'd1);
    if (lines) check_lines("lines");
  endtask

  initial begin
    bit eh, ew;
    idle_inputs();
    model_reset();
    #25;
    check("rst_bus_ready", 32'(sb.bus_ready), 32'd1);
    check("rst_upd_ready", 32'(sb.cpu_upd_ready), 32'd1);
    check("rst_wb_valid", 32'(sb.wb_valid), 32'd0);
    check("rst_abort", 32'(sb.abort_mem), 32'd0);
    check("rst_done", 32'(sb.snoop_done), 32'd0);
    check("rst_hit", 32'(sb.snoop_hit), 32'd0);
    check("rst_wb_idx", 32'(sb.wb_idx), 32'd0);
    check("rst_wb_tag", 32'(sb.wb_tag), 32'd0);
    check_lines("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Exclusive line hit by a read miss: write-back, then shared.
    cpu_upd(2'd1, 8'h3A, 2'd1);
    bus_txn(2'd0, 2'd1, 8'h3A, 1'b0, '0, '0, 2'd0, 3, 1'b1);
    sb.cpu_rd_idx = 2'd1;
    #1 check("t1_state", 32'(sb.cpu_rd_state), 32'h2);

    // Shared line invalidated, no write-back.
    cpu_upd(2'd2, 8'h05, 2'd2);
    bus_txn(2'd2, 2'd2, 8'h05, 1'b0, '0, '0, 2'd0, 0, 1'b1);

    // Tag mismatch on an exclusive line is a miss.
    cpu_upd(2'd0, 8'h10, 2'd1);
    bus_txn(2'd1, 2'd0, 8'h11, 1'b0, '0, '0, 2'd0, 0, 1'b1);

    // Empty message with a concurrent CPU update.
    bus_txn(2'd3, 2'd3, 8'h77, 1'b1, 2'd3, 8'h77, 2'd2, 0, 1'b1);

    // Encoding 11 is stored as invalid.
    cpu_upd(2'd2, 8'h44, 2'd3);
    check_lines("upd11");

    // Concurrent update to the snooped line is visible to the lookup.
    bus_txn(2'd1, 2'd2, 8'h55, 1'b1, 2'd2, 8'h55, 2'd1, 1, 1'b1);

    // Randomized mix of updates and snoops.
    for (int n = 0; n < 200; n++) begin
      logic [IDX_W-1:0] idx, uidx;
      logic [TAG_W-1:0] tag, utag;
      idx  = IDX_W'($urandom_range(0, LINES - 1));
      uidx = IDX_W'($urandom_range(0, LINES - 1));
      utag = TAG_W'($urandom_range(0, 3));
      tag  = ($urandom_range(0, 3) == 0) ? TAG_W'($urandom_range(0, 3)) : ref_tag[idx];
      if ($urandom_range(0, 3) == 0)
        cpu_upd(uidx, utag, 2'($urandom_range(0, 3)));
      else
        bus_txn(2'($urandom_range(0, 3)), idx, tag, 1'($urandom_range(0, 1)),
                uidx, utag, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset while a write-back is pending.
    cpu_upd(2'd1, 8'h3A, 2'd1);
    @(negedge clock);
    sb.bus_valid = 1'b1;
    sb.bus_msg   = 2'd0;
    sb.bus_idx   = 2'd1;
    sb.bus_tag   = 8'h3A;
    @(posedge clock);
    #1 sb.bus_valid = 1'b0;
    model_snoop(2'd0, 2'd1, 8'h3A, eh, ew);
    @(negedge clock);
    @(negedge clock);
    check("rmid_wb_pending", 32'(sb.wb_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rmid_wb_drop", 32'(sb.wb_valid), 32'd0);
    check("rmid_bus_ready", 32'(sb.bus_ready), 32'd1);
    model_reset();
    check_lines("rmid");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rmid_no_done", 32'(sb.snoop_done), 32'd0);
      check("rmid_ready", 32'(sb.bus_ready), 32'd1);
    end
    bus_txn(2'd2, 2'd0, 8'h00, 1'b0, '0, '0, 2'd0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
